// File: rtl/system_0_led_pwm_driver_pkg.sv
// Shared definitions for the LED PWM driver: default sizes, the
// brightness/counter maximum, and the timebase strobe bundle.
// Optional blinking is controlled by the LED_PWM_BLINK_EN macro.
package system_0_led_pwm_driver_pkg;

    // Default geometry (matches the 18-bit red-LED PIO)
    localparam int N_LEDS_DEF     = 18;
    localparam int PWM_BITS_DEF   = 4;
    localparam int PRESCALE_DEF   = 4;
    localparam int BLINK_BITS_DEF = 8;

    // Largest PWM count / brightness code; this code means "always on"
    localparam int PWM_MAX = 2**PWM_BITS_DEF - 1;

    // Strobes produced by the timebase once per clk
    typedef struct packed {
        logic tick;   // last clk of a prescaler interval
        logic bnd;    // last tick of a PWM period
    } pwm_strobe_t;

    // Counter width that stays legal (>= 1 bit) even for a modulus of 1
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/system_0_led_pwm_driver_if.sv
// Signal bundle between the PIO side and the LED PWM driver.
// master = whoever supplies the pattern/brightness; slave = the driver.
interface system_0_led_pwm_driver_if #(
    parameter int N_LEDS     = 18,
    parameter int PWM_BITS   = 4,
    parameter int BLINK_BITS = 8
);
    logic [N_LEDS-1:0]     led_in;
    logic [PWM_BITS-1:0]   brightness;
    logic                  blink_en;
    logic [BLINK_BITS-1:0] blink_periods;
    logic [N_LEDS-1:0]     led_out;
    logic                  period_start;

    modport master (
        output led_in, brightness, blink_en, blink_periods,
        input  led_out, period_start
    );

    modport slave (
        input  led_in, brightness, blink_en, blink_periods,
        output led_out, period_start
    );
endinterface

// File: rtl/system_0_led_pwm_driver_timebase.sv
// PWM timebase: a prescaler dividing clk into ticks and a free-running
// PWM counter advanced once per tick. Emits tick, the period boundary
// strobe (last tick of a period) and the current PWM count.
module system_0_led_pwm_driver_timebase
    import system_0_led_pwm_driver_pkg::*;
#(
    parameter int PWM_BITS = PWM_BITS_DEF,
    parameter int PRESCALE = PRESCALE_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    output pwm_strobe_t         strobe,
    output logic [PWM_BITS-1:0] pwm_cnt
);

    // With PRESCALE=1 the counter is a single bit pinned at 0, so tick is constant 1
    localparam int                 PRE_W    = clog2_min1(PRESCALE);
    localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_LAST = '1;

    logic [PRE_W-1:0] pre_cnt;

    // Decode tick and period boundary from the current counter state
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        strobe      = '0;
        strobe.tick = (pre_cnt == PRE_LAST);
        strobe.bnd  = strobe.tick && (pwm_cnt == CNT_LAST);
    end

    // Prescaler wraps on tick; PWM counter advances on tick and wraps naturally
    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
        end else begin
            if (strobe.tick) begin
                pre_cnt <= '0;
                pwm_cnt <= pwm_cnt + 1'b1;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/system_0_led_pwm_driver.sv
// LED PWM driver: sits between the red-LED PIO out_port and the LEDR pins.
// Pattern and brightness are shadowed at PWM period boundaries so a change
// never glitches mid-period; the shadowed pattern is gated by a PWM compare
// and registered onto led_out. period_start pulses for the first clk of
// each period.
// Optional blinking is built only when LED_PWM_BLINK_EN is defined; without
// it blink_en and blink_periods are ignored and the blink gate is always open.
module system_0_led_pwm_driver
    import system_0_led_pwm_driver_pkg::*;
#(
    parameter int N_LEDS     = N_LEDS_DEF,
    parameter int PWM_BITS   = PWM_BITS_DEF,
    parameter int PRESCALE   = PRESCALE_DEF,
    parameter int BLINK_BITS = BLINK_BITS_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    system_0_led_pwm_driver_if.slave  bus
);

    localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

    pwm_strobe_t         strobe;
    logic [PWM_BITS-1:0] pwm_cnt;

    logic [N_LEDS-1:0]   pattern_q;
    logic [PWM_BITS-1:0] bright_q;
    logic                period_start_q;
    logic [N_LEDS-1:0]   led_q;
    logic                blink_phase;
    logic                pwm_on;

    system_0_led_pwm_driver_timebase #(
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE)
    ) u_timebase (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (strobe),
        .pwm_cnt (pwm_cnt)
    );

    // Shadow pattern/brightness at each boundary and flag the new period
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pattern_q      <= '0;
            bright_q       <= '0;
            period_start_q <= 1'b0;
        end else begin
            period_start_q <= strobe.bnd;
            if (strobe.bnd) begin
                pattern_q <= bus.led_in;
                bright_q  <= bus.brightness;
            end
        end
    end

    // Full-scale code is 100% on; otherwise lit while the count is below the duty
    assign pwm_on = (bright_q == BRIGHT_MAX) || (pwm_cnt < bright_q);

`ifdef LED_PWM_BLINK_EN
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [BLINK_BITS-1:0] blink_last;

    // Last boundary count of a half-phase; a period setting of 0 behaves as 1
    always_comb begin
        blink_last = '0;
        if (bus.blink_periods != '0) begin
            blink_last = bus.blink_periods - 1'b1;
        end
    end

    // Count boundaries while enabled and flip the phase every blink_periods of them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!bus.blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (strobe.bnd) begin
            if (blink_cnt == blink_last) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    // Blinking not built: the gate is permanently open
    assign blink_phase = 1'b1;

    logic unused_blink;
    assign unused_blink = ^{bus.blink_en, bus.blink_periods};
`endif

    // Register the gated pattern onto the pins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= '0;
        end else begin
            led_q <= pattern_q & {N_LEDS{pwm_on & blink_phase}};
        end
    end

    assign bus.led_out      = led_q;
    assign bus.period_start = period_start_q;

endmodule
